mcpu_alu_arbiter: RTL and testbench
===================================

MCPU_ALU_ARBITER -- requirements
Module: mcpu_alu_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost accept-cycles before requester 1 is force-granted (legal 1..15).
REQ-002 SHALL have port clkrst_core_clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port clkrst_core_rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports r0_valid / r1_valid  input  1  each requester presents an ALU operation.
REQ-005 SHALL have ports r0_ready / r1_ready  output  1  operation accepted this cycle when valid&ready.
REQ-006 SHALL have ports r0_operands / r1_operands  input  64  {rs_data[31:0], sop[31:0]}.
REQ-007 SHALL have ports r0_ctl / r1_ctl  input  15  {opcode[3:0], compare_type[2:0], shift_type[1:0], shift_amount[5:0]}.
REQ-008 SHALL have ports alu_operands  output  64, and alu_ctl  output  15, both driving the shared combinational ALU.
REQ-009 SHALL have ports alu_result  input  32, and alu_invalid  input  1, both returned by the ALU in the same cycle.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (0=r0, 1=r1), rsp_result  output  32, rsp_invalid  output  1.

Function
REQ-011 SHALL drive alu_operands/alu_ctl from the granted requester every cycle; grant to r0 when no request is valid.
REQ-012 SHALL define slot_free = ~rsp_valid | rsp_ready; at most one of r0_ready/r1_ready SHALL be 1, and only when slot_free and that requester is granted and valid.
REQ-013 SHALL register on acceptance, at the next edge: rsp_valid=1, rsp_id=granted index, rsp_result, rsp_invalid=alu_invalid; latency is exactly 1 cycle.
REQ-014 SHALL, when the accepted opcode is 4'b0111, register rsp_result as {31'b0, alu_result[0]}; all other opcodes SHALL pass all 32 bits unmodified.
REQ-015 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0; SHALL clear rsp_valid when rsp_ready=1 and no new acceptance occurs.
REQ-016 SHALL sustain one acceptance per cycle while rsp_ready stays 1 (accept and drain in the same cycle).
REQ-017 SHALL, in default arbitration, grant r0 when r0_valid, unless starve_cnt == STARVE_LIMIT and r1_valid, in which case r1 is granted.
REQ-018 SHALL keep a 4-bit starve_cnt: increment (saturating at STARVE_LIMIT) in each cycle where r1_valid=1, slot_free=1, and r0 is accepted; clear when r1 is accepted or r1_valid=0; otherwise hold.
REQ-019 SHALL never change rsp_* or starve_cnt while slot_free=0 (stall freezes arbitration state).
REQ-020 SHALL require requesters to hold valid and payload until accepted; behaviour on withdrawal is undefined and SHALL not corrupt a pending response.

Reset
REQ-021 SHALL, on clkrst_core_rst=1 at a clock edge, set rsp_valid=0, rsp_id=0, rsp_result=0, rsp_invalid=0, starve_cnt=0, and rr_last=1.
REQ-022 SHALL drive r0_ready=r1_ready=0 during any cycle where clkrst_core_rst=1.
REQ-023 SHALL drop any pending response on reset mid-operation, with no replay afterwards.

Configuration
REQ-024 SHALL, with MCPU_ALU_ARB_RR_EN defined, replace REQ-017/018 with round-robin arbitration:
  - if both requesters are valid, grant the one not equal to rr_last;
  - rr_last updates only on acceptance;
  - starve_cnt is absent and STARVE_LIMIT is ignored.
REQ-025 SHALL, without MCPU_ALU_ARB_RR_EN, use fixed r0 priority with the starvation guard; the port list is identical in both builds.

Verification
REQ-026 Single op: r1 only, opcode 0000, rs=5, sop=7, shift 0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=1, rsp_result=12, rsp_invalid=0.
REQ-027 Compare masking: opcode 0111, compare_type 000, rs=1, sop=2 -> rsp_result=32'h00000001; with compare_type 011 -> rsp_invalid=1.
REQ-028 Stall: accept op A with rsp_ready=0 for 3 cycles -> rsp_* hold A, both readies=0; rsp_ready=1 -> next op is accepted in that same cycle.
REQ-029 Starvation (default build): both valid continuously, rsp_ready=1, STARVE_LIMIT=4 -> grant sequence r0,r0,r0,r0,r1,r0,r0,r0,r0,r1...
REQ-030 RR build: both valid continuously -> grants alternate r0,r1,r0,r1 from reset.
REQ-031 Reset mid-op: rsp_valid=1, rsp_ready=0, assert reset 1 cycle -> rsp_valid=0 next cycle; first post-reset tie grants r0.

Source files
------------

// File: rtl/mcpu_alu_arbiter.sv
// ----------------------------------------------------------------------------
// mcpu_alu_arbiter
//   Two-requester arbiter in front of one shared combinational ALU. The
//   granted requester's operands/ctl are steered to the ALU every cycle. An
//   accepted operation's result is registered into a one-deep response slot,
//   so latency is one cycle. The slot drains and refills in the same cycle,
//   which gives one acceptance per cycle while rsp_ready stays high.
//
//   Build option (macro MCPU_ALU_ARB_RR_EN):
//     undefined : r0 has fixed priority. A starvation guard force-grants r1
//                 after STARVE_LIMIT consecutive accept-cycles lost to r0.
//     defined   : round-robin on ties. STARVE_LIMIT is ignored.
//
// Ports
//   clkrst_core_clk / clkrst_core_rst : clock, synchronous active-high reset
//   r{0,1}_valid/ready                : requester handshakes
//   r{0,1}_operands                   : {rs_data[31:0], sop[31:0]}
//   r{0,1}_ctl                        : {opcode[3:0], compare_type[2:0],
//                                        shift_type[1:0], shift_amount[5:0]}
//   alu_operands / alu_ctl            : to the shared ALU
//   alu_result / alu_invalid          : from the ALU, same cycle
//   rsp_valid/ready/id/result/invalid : registered response (id 0=r0, 1=r1)
// ----------------------------------------------------------------------------
module mcpu_alu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [63:0] r0_operands,
    input  logic [14:0] r0_ctl,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [63:0] r1_operands,
    input  logic [14:0] r1_ctl,
    output logic [63:0] alu_operands,
    output logic [14:0] alu_ctl,
    input  logic [31:0] alu_result,
    input  logic        alu_invalid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_invalid
);

    localparam logic [3:0] OP_CMP = 4'b0111;

    logic        slot_free;
    logic        grant;      // 0 = r0, 1 = r1; r0 when nobody is valid
    logic        accept;
    logic [31:0] res_masked;

    // The slot can take a new result when it is empty or draining this cycle.
    assign slot_free = ~rsp_valid | rsp_ready;

`ifdef MCPU_ALU_ARB_RR_EN
    logic rr_last;

    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) grant = ~rr_last;
        else if (r1_valid)        grant = 1'b1;
    end

    // Reset value 1 makes the first tie after reset go to r0.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) rr_last <= 1'b1;
        else if (accept)     rr_last <= grant;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    always_comb begin
        grant = 1'b0;
        if (r1_valid && (!r0_valid || starve_cnt == LIMIT)) grant = 1'b1;
    end

    // Counts accept-cycles r1 lost to r0. Frozen while the slot is stalled;
    // when the slot is free and r1 is valid somebody is always accepted.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            starve_cnt <= 4'd0;
        end else if (slot_free) begin
            if (!r1_valid || r1_ready)
                starve_cnt <= 4'd0;
            else if (r0_ready && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    assign r0_ready = ~clkrst_core_rst & slot_free & r0_valid & ~grant;
    assign r1_ready = ~clkrst_core_rst & slot_free & r1_valid &  grant;
    assign accept   = r0_ready | r1_ready;

    assign alu_operands = grant ? r1_operands : r0_operands;
    assign alu_ctl      = grant ? r1_ctl      : r0_ctl;

    // Compares only produce a boolean; upper ALU bits are don't-care there.
    assign res_masked = (alu_ctl[14:11] == OP_CMP) ? {31'b0, alu_result[0]}
                                                   : alu_result;

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_invalid <= 1'b0;
        end else if (accept) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= grant;
            rsp_result  <= res_masked;
            rsp_invalid <= alu_invalid;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mcpu_alu_arbiter
//   Bench for the default (fixed-priority + starvation guard) build. A small
//   ALU model answers the DUT's ALU port. A reference model predicts which
//   requester wins each cycle and what the response slot holds.
// ----------------------------------------------------------------------------
module tb_mcpu_alu_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [63:0] r0_operands, r1_operands, alu_operands;
    logic [14:0] r0_ctl, r1_ctl, alu_ctl;
    logic [31:0] alu_result, rsp_result;
    logic        alu_invalid, rsp_valid, rsp_ready, rsp_id, rsp_invalid;

    always #5 clk = ~clk;

    mcpu_alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clkrst_core_clk(clk),       .clkrst_core_rst(rst),
        .r0_valid(r0_valid),         .r0_ready(r0_ready),
        .r0_operands(r0_operands),   .r0_ctl(r0_ctl),
        .r1_valid(r1_valid),         .r1_ready(r1_ready),
        .r1_operands(r1_operands),   .r1_ctl(r1_ctl),
        .alu_operands(alu_operands), .alu_ctl(alu_ctl),
        .alu_result(alu_result),     .alu_invalid(alu_invalid),
        .rsp_valid(rsp_valid),       .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),             .rsp_result(rsp_result),
        .rsp_invalid(rsp_invalid)
    );

    // Toy ALU: add, compare (with junk in the upper bits), or xor+shamt.
    function automatic logic [31:0] alu_fn(input logic [63:0] ops, input logic [14:0] ctl);
        logic [31:0] rs, sop;
        logic        c;
        rs  = ops[63:32];
        sop = ops[31:0];
        case (ctl[10:8])
            3'b000:  c = rs < sop;
            3'b001:  c = rs == sop;
            default: c = $signed(rs) < $signed(sop);
        endcase
        case (ctl[14:11])
            4'b0000: return rs + sop;
            4'b0111: return {31'h2AAAAAAA, c};
            default: return (rs ^ sop) + {26'b0, ctl[5:0]};
        endcase
    endfunction

    function automatic logic alu_inv_fn(input logic [14:0] ctl);
        return ctl[14:11] == 4'b0111 && ctl[10:8] == 3'b011;
    endfunction

    assign alu_result  = alu_fn(alu_operands, alu_ctl);
    assign alu_invalid = alu_inv_fn(alu_ctl);

    function automatic logic [31:0] exp_result(input logic [63:0] ops, input logic [14:0] ctl);
        logic [31:0] r;
        r = alu_fn(ops, ctl);
        return (ctl[14:11] == 4'b0111) ? {31'b0, r[0]} : r;
    endfunction

    function automatic logic [14:0] rand_ctl();
        logic [3:0] op;
        logic [31:0] u;
        u = $urandom;
        case ($urandom_range(0, 2))
            0:       op = 4'b0000;
            1:       op = 4'b0111;
            default: op = u[14:11];
        endcase
        return {op, u[10:0]};
    endfunction

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    // Reference model state: response slot contents and r1's lost-cycle run.
    logic        m_valid = 1'b0, m_id = 1'b0, m_inv = 1'b0;
    logic [31:0] m_res = 32'd0;
    int          m_lost = 0;
    logic        acc0, acc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshakes against the model before the edge, then
    // advance the model and check the registered response after it.
    task automatic step();
        int          win;
        logic        sf;
        logic [31:0] e_res;
        logic        e_inv;
        #1;
        sf  = !m_valid || rsp_ready;
        win = -1;
        if (!rst && sf) begin
            if (r0_valid && r1_valid) win = (m_lost >= LIMIT) ? 1 : 0;
            else if (r1_valid)        win = 1;
            else if (r0_valid)        win = 0;
        end
        chk("r0_ready", 64'(r0_ready), 64'(win == 0));
        chk("r1_ready", 64'(r1_ready), 64'(win == 1));
        e_res = 32'd0;
        e_inv = 1'b0;
        if (win >= 0) begin
            chk("alu_ctl", 64'(alu_ctl), 64'(win == 1 ? r1_ctl : r0_ctl));
            chk("alu_ops", alu_operands, (win == 1) ? r1_operands : r0_operands);
            e_res = (win == 1) ? exp_result(r1_operands, r1_ctl) : exp_result(r0_operands, r0_ctl);
            e_inv = (win == 1) ? alu_inv_fn(r1_ctl) : alu_inv_fn(r0_ctl);
        end
        acc0 = (win == 0);
        acc1 = (win == 1);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_id = 1'b0; m_res = 32'd0; m_inv = 1'b0; m_lost = 0;
            chk("rst_valid",  64'(rsp_valid),   64'd0);
            chk("rst_id",     64'(rsp_id),      64'd0);
            chk("rst_result", 64'(rsp_result),  64'd0);
            chk("rst_inv",    64'(rsp_invalid), 64'd0);
        end else begin
            if (sf) begin
                if (!r1_valid || win == 1) m_lost = 0;
                else if (win == 0)         m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
            end
            if (win >= 0) begin
                m_valid = 1'b1; m_id = (win == 1); m_res = e_res; m_inv = e_inv;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rsp_id",      64'(rsp_id),      64'(m_id));
                chk("rsp_result",  64'(rsp_result),  64'(m_res));
                chk("rsp_invalid", 64'(rsp_invalid), 64'(m_inv));
            end
        end
    endtask

    logic [0:9] starve_exp;

    initial begin
        rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_operands = '0; r1_operands = '0; r0_ctl = '0; r1_ctl = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        @(negedge clk);

        // Reset state.
        step();
        step();
        rst = 1'b0;

        // Single op from r1: 5 + 7.
        rsp_ready = 1'b1;
        r1_valid = 1'b1; r1_operands = {32'd5, 32'd7}; r1_ctl = 15'd0;
        step();
        r1_valid = 1'b0;
        chk("single_id",  64'(rsp_id),      64'd1);
        chk("single_res", 64'(rsp_result),  64'd12);
        chk("single_inv", 64'(rsp_invalid), 64'd0);

        // Compare masking, then invalid compare type.
        r0_valid = 1'b1; r0_operands = {32'd1, 32'd2}; r0_ctl = {4'b0111, 3'b000, 8'd0};
        step();
        chk("cmp_res", 64'(rsp_result), 64'h1);
        r0_ctl = {4'b0111, 3'b011, 8'd0};
        step();
        chk("cmp_inv", 64'(rsp_invalid), 64'd1);
        r0_valid = 1'b0;
        step();

        // Stall: A accepted with rsp_ready low, B waits three cycles.
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_operands = {32'hA0, 32'h0A}; r0_ctl = 15'd0;
        step();
        r0_operands = {32'hB0, 32'h0B};
        repeat (3) step();
        chk("stall_hold", 64'(rsp_result), 64'hAA);
        rsp_ready = 1'b1;
        step();
        chk("stall_accept", 64'(rsp_result), 64'hBB);
        r0_valid = 1'b0;
        step();

        // Starvation guard: both valid continuously.
        starve_exp = 10'b0000100001;
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r0_operands = {$urandom, $urandom}; r1_operands = {$urandom, $urandom};
            r0_ctl = rand_ctl(); r1_ctl = rand_ctl();
            step();
            chk($sformatf("starve_grant%0d", i), 64'(acc1 ? r1_ready : 1'b0) | 64'(rsp_id), 64'(starve_exp[i]));
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        // Reset with a response pending, then a tie goes to r0.
        rsp_ready = 1'b0;
        r1_valid = 1'b1; r1_operands = {32'd3, 32'd4}; r1_ctl = 15'd0;
        step();
        r1_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        step();
        chk("post_rst_tie", 64'(rsp_id), 64'd0);

        // Randomized traffic; valid and payload held until accepted.
        for (int n = 0; n < 600; n++) begin
            if (!r0_valid || acc0) begin
                r0_valid = $urandom_range(0, 3) != 0;
                r0_operands = {$urandom, $urandom}; r0_ctl = rand_ctl();
            end
            if (!r1_valid || acc1) begin
                r1_valid = $urandom_range(0, 3) != 0;
                r1_operands = {$urandom, $urandom}; r1_ctl = rand_ctl();
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 99) == 0;
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
